// File: rtl/fclassify_pipe.sv
// fclassify_pipe: pipelined FP classify for half/single/double/quad operands.
// Define FCLASSIFY_NANBOX_EN to classify improperly NaN-boxed narrow operands as canonical qNaN.
module fclassify_pipe #(
  parameter int XLEN   = 64,
  parameter int FLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] X,
  input  logic [1:0]      Fmt,
  input  logic [TAGW-1:0] InTag,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] ClassRes,
  output logic            FmtErr,
  output logic [TAGW-1:0] OutTag
);
  logic [127:0] xw;
  logic [7:0] fw;
  logic sgn, e_ones, e_zero, f_zero, f_msb, fmt_err, boxed, acc;
  logic [9:0] cls;
  logic [STAGES-1:0] v_q, v_d, rdy, err_q, err_d;
  logic [STAGES-1:0][XLEN-1:0] res_q, res_d;
  logic [STAGES-1:0][TAGW-1:0] tag_q, tag_d;
  always_comb begin
    xw = 128'(X);
    sgn = 1'b0;
    e_ones = 1'b0;
    e_zero = 1'b0;
    f_zero = 1'b0;
    f_msb = 1'b0;
    fw = 8'd0;
    case (Fmt)
      2'b00: begin
        sgn = xw[31]; e_ones = &xw[30:23]; e_zero = ~|xw[30:23];
        f_zero = ~|xw[22:0]; f_msb = xw[22]; fw = 8'd32;
      end
      2'b01: begin
        sgn = xw[63]; e_ones = &xw[62:52]; e_zero = ~|xw[62:52];
        f_zero = ~|xw[51:0]; f_msb = xw[51]; fw = 8'd64;
      end
      2'b10: begin
        sgn = xw[15]; e_ones = &xw[14:10]; e_zero = ~|xw[14:10];
        f_zero = ~|xw[9:0]; f_msb = xw[9]; fw = 8'd16;
      end
      default: begin
        sgn = xw[127]; e_ones = &xw[126:112]; e_zero = ~|xw[126:112];
        f_zero = ~|xw[111:0]; f_msb = xw[111]; fw = 8'd128;
      end
    endcase
    fmt_err = fw > 8'(FLEN);
  end
`ifdef FCLASSIFY_NANBOX_EN
  logic [127:0] lo_mask, fl_mask;
  // Bits above the format but inside FLEN must all be ones.
  always_comb begin
    lo_mask = (128'd1 << fw) - 128'd1;
    fl_mask = (128'd1 << FLEN) - 128'd1;
    boxed = &(xw | lo_mask | ~fl_mask);
  end
`else
  always_comb boxed = 1'b1;
`endif
  always_comb
    cls = fmt_err ? 10'h000 :
          !boxed  ? 10'h200 :
          e_ones  ? (f_zero ? (sgn ? 10'h001 : 10'h080) : (f_msb ? 10'h200 : 10'h100)) :
          e_zero  ? (f_zero ? (sgn ? 10'h008 : 10'h010) : (sgn ? 10'h004 : 10'h020)) :
                    (sgn ? 10'h002 : 10'h040);
  // A stage can load when it is empty or everything downstream moves.
  always_comb begin
    acc = OutReady;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc = acc | ~v_q[i];
      rdy[i] = acc;
    end
  end
  always_comb begin
    v_d = v_q;
    res_d = res_q;
    err_d = err_q;
    tag_d = tag_q;
    if (rdy[0]) begin
      v_d[0] = InValid;
      res_d[0] = XLEN'(cls);
      err_d[0] = fmt_err;
      tag_d[0] = InTag;
    end
    for (int i = 1; i < STAGES; i++)
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        res_d[i] = res_q[i-1];
        err_d[i] = err_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    if (Flush) v_d = '0;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      v_q <= '0;
      res_q <= '0;
      err_q <= '0;
      tag_q <= '0;
    end else begin
      v_q <= v_d;
      res_q <= res_d;
      err_q <= err_d;
      tag_q <= tag_d;
    end
  assign InReady = rdy[0];
  assign OutValid = v_q[STAGES-1];
  assign ClassRes = res_q[STAGES-1];
  assign FmtErr = err_q[STAGES-1];
  assign OutTag = tag_q[STAGES-1];
endmodule

// File: tb/tb_fclassify_pipe.sv
// tb_fclassify_pipe: directed bench with a scoreboard queue for fclassify_pipe (default parameters).
module tb_fclassify_pipe;
  logic clk, reset_n, Flush, InValid, InReady, OutValid, OutReady, FmtErr;
  logic [63:0] X, ClassRes;
  logic [1:0] Fmt;
  logic [4:0] InTag, OutTag;
  logic [63:0] exp_res;
  logic exp_err;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [63:0] res; logic err; logic [4:0] tag;} exp_t;
  exp_t q[$];
  exp_t e;
  localparam logic [63:0] VX [17] = '{
    64'hFFF0000000000000, 64'h7FF4000000000000, 64'h7FF8000000000000, 64'h0000000000000001,
    64'h8000000000000000, 64'hFFFFFFFF3F800000, 64'h000000003F800000, 64'hFFFFFFFFFFFF7C00,
    64'h8000000000000001, 64'hFFF8000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
    64'h0000000000000000, 64'h7FF0000000000000, 64'hFFFFFFFFFF800000, 64'hFFFFFFFFFFFF8001,
    64'h123456789ABCDEF0};
  localparam logic [1:0] VF [17] = '{
    2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
    2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
`ifdef FCLASSIFY_NANBOX_EN
  localparam logic [9:0] UNBOXED = 10'h200;
`else
  localparam logic [9:0] UNBOXED = 10'h040;
`endif
  localparam logic [9:0] VE [17] = '{
    10'h001, 10'h100, 10'h200, 10'h020, 10'h008, 10'h040, UNBOXED, 10'h080,
    10'h004, 10'h200, 10'h040, 10'h002, 10'h010, 10'h080, 10'h001, 10'h004, 10'h000};

  fclassify_pipe dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .X(X), .Fmt(Fmt), .InTag(InTag), .OutValid(OutValid), .OutReady(OutReady),
    .ClassRes(ClassRes), .FmtErr(FmtErr), .OutTag(OutTag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: check departing results, then record newly accepted inputs.
  always @(negedge clk) begin
    if (!reset_n || Flush) q.delete();
    else begin
      if (OutValid && OutReady) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_bad++;
          $error("FAIL spurious_out: got tag %0d res %0h, expected no output", OutTag, ClassRes);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          assert (ClassRes === e.res && FmtErr === e.err && OutTag === e.tag) else begin
            n_bad++;
            $error("FAIL out_tag%0d: got res %0h err %b tag %0d, expected res %0h err %b tag %0d",
                   e.tag, ClassRes, FmtErr, OutTag, e.res, e.err, e.tag);
          end
        end
      end
      if (InValid && InReady) q.push_back({exp_res, exp_err, InTag});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic drive(input int idx, input logic [4:0] tag);
    InValid = 1'b1;
    X = VX[idx];
    Fmt = VF[idx];
    InTag = tag;
    exp_res = 64'(VE[idx]);
    exp_err = VF[idx] == 2'b11;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stream with OutReady dropped for cycles lo..hi.
  task automatic stream(input int first, input int n, input int lo, input int hi);
    int k = 0;
    for (int c = 0; c < 60 && (k < n || q.size() > 0); c++) begin
      OutReady = !(c >= lo && c <= hi);
      InValid = 1'b0;
      if (k < n) drive(first + k, 5'(first + k));
      @(negedge clk);
      if (c >= lo && c <= hi) begin
        chk("stall_inready", 64'(InReady), 64'd0);
        chk("stall_outvalid", 64'(OutValid), 64'd1);
        chk("stall_tag", 64'(OutTag), 64'(first + 1));
        chk("stall_res", ClassRes, 64'(VE[first+1]));
      end
      if (InValid && InReady) k++;
      @(posedge clk);
      #1;
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    chk("stream_accepted", 64'(k), 64'(n));
    chk("stream_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    X = '0; Fmt = '0; InTag = '0; exp_res = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_inready", 64'(InReady), 64'd1);
    chk("rst_classres", ClassRes, 64'd0);
    chk("rst_fmterr", 64'(FmtErr), 64'd0);
    chk("rst_outtag", 64'(OutTag), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stream(0, 8, 3, 5);
    stream(8, 9, 100, -1);
    OutReady = 1'b0;
    drive(0, 5'd20); step();
    drive(1, 5'd21); step();
    drive(2, 5'd22); Flush = 1'b1; step();
    Flush = 1'b0; InValid = 1'b0;
    @(negedge clk);
    chk("flush_outvalid", 64'(OutValid), 64'd0);
    chk("flush_inready", 64'(InReady), 64'd1);
    @(posedge clk); #1;
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_out", 64'(OutValid), 64'd0);
      @(posedge clk); #1;
    end
    OutReady = 1'b0;
    drive(3, 5'd23); step();
    drive(4, 5'd24); step();
    drive(5, 5'd25); reset_n = 1'b0; step();
    reset_n = 1'b1; InValid = 1'b0;
    @(negedge clk);
    chk("mrst_outvalid", 64'(OutValid), 64'd0);
    chk("mrst_inready", 64'(InReady), 64'd1);
    chk("mrst_classres", ClassRes, 64'd0);
    @(posedge clk); #1;
    OutReady = 1'b1;
    drive(10, 5'd26);
    @(negedge clk);
    chk("lat_accept", 64'(InReady), 64'd1);
    @(posedge clk); #1;
    InValid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 64'(OutValid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2", 64'(OutValid), 64'd1);
    chk("lat_tag", 64'(OutTag), 64'd26);
    @(posedge clk); #1;
    repeat (3) step();
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
